// File: rtl/fetch_decode_queue_pkg.sv
// Shared Y86 types for the fetch->decode queue: stat codes, bundle layout,
// and the bubble bundle decode sees when nothing is queued.
package fetch_decode_queue_pkg;

    localparam int FD_PC_W = 64;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        stat_e               stat;
        logic [FD_PC_W-1:0]  pc;
        logic [3:0]          icode;
        logic [3:0]          ifun;
        logic [3:0]          ra;
        logic [3:0]          rb;
        logic [FD_PC_W-1:0]  valc;
        logic [FD_PC_W-1:0]  valp;
    } fd_bundle_t;

    localparam fd_bundle_t FD_BUBBLE = '{
        stat:  SAOK,
        pc:    '0,
        icode: INOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  '0,
        valp:  '0
    };

    function automatic logic is_fault(input logic [2:0] s);
        return s != 3'(SAOK);
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side push handshake and decode-side head/control signals.
// master = fetch+decode environment, slave = the queue.
interface fetch_decode_queue_if #(
    parameter int PC_W  = 64,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             f_valid;
    logic             f_ready;
    logic [2:0]       f_stat;
    logic [PC_W-1:0]  f_pc;
    logic [3:0]       f_icode;
    logic [3:0]       f_ifun;
    logic [3:0]       f_ra;
    logic [3:0]       f_rb;
    logic [PC_W-1:0]  f_valc;
    logic [PC_W-1:0]  f_valp;

    logic             d_stall;
    logic             d_bubble;
    logic             d_valid;
    logic [2:0]       d_stat;
    logic [PC_W-1:0]  d_pc;
    logic [3:0]       d_icode;
    logic [3:0]       d_ifun;
    logic [3:0]       d_ra;
    logic [3:0]       d_rb;
    logic [PC_W-1:0]  d_valc;
    logic [PC_W-1:0]  d_valp;
    logic [CNT_W-1:0] count;

    modport master (
        output f_valid, f_stat, f_pc, f_icode, f_ifun,
               f_ra, f_rb, f_valc, f_valp,
        output d_stall, d_bubble,
        input  f_ready,
        input  d_valid, d_stat, d_pc, d_icode, d_ifun,
               d_ra, d_rb, d_valc, d_valp, count
    );

    modport slave (
        input  f_valid, f_stat, f_pc, f_icode, f_ifun,
               f_ra, f_rb, f_valc, f_valp,
        input  d_stall, d_bubble,
        output f_ready,
        output d_valid, d_stat, d_pc, d_icode, d_ifun,
               d_ra, d_rb, d_valc, d_valp, count
    );

endinterface

// File: rtl/fetch_decode_queue_storage.sv
// Bundle storage: one write port, asynchronous head read.
// Data is never reset; the queue's count decides which entries are live.
module fdq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// F->D instruction queue; head drives decode like the old D register.
// FDQ_BYPASS_EN: empty-queue pushes pass straight to D_* with zero latency.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = FD_PC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_decode_queue_if.slave  q
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int BW    = 3 * PC_W + 19;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] count;
    logic             halt;

    logic [BW-1:0]    f_bundle;
    logic [BW-1:0]    head;
    logic [BW-1:0]    d_bundle;
    logic [BW-1:0]    bubble_bundle;
    logic             d_valid;

    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             byp;
    logic             wr_en;

    assign bubble_bundle = {
        SAOK, {PC_W{1'b0}}, INOP, 4'h0,
        RNONE, RNONE, {PC_W{1'b0}}, {PC_W{1'b0}}
    };

    assign f_bundle = {
        q.f_stat, q.f_pc, q.f_icode, q.f_ifun,
        q.f_ra, q.f_rb, q.f_valc, q.f_valp
    };

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign pop       = ~empty & ~q.d_stall & ~q.d_bubble;
    assign q.f_ready = ~halt & ~q.d_bubble & (~full | pop);
    assign push      = q.f_valid & q.f_ready;

`ifdef FDQ_BYPASS_EN
    assign byp = empty & push & ~q.d_stall;
`else
    assign byp = 1'b0;
`endif

    // A bypassed bundle is consumed by decode directly and never stored
    assign wr_en = push & ~byp;

    fdq_storage #(
        .DEPTH (DEPTH),
        .W     (BW)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (f_bundle),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            halt   <= 1'b0;
        end else if (q.d_bubble) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            halt   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
            // Stop fetching past HLT/ADR/INS, bypassed or not
            if (push && is_fault(q.f_stat)) begin
                halt <= 1'b1;
            end
        end
    end

    always_comb begin
        d_bundle = bubble_bundle;
        d_valid  = 1'b0;
        unique case (1'b1)
            !empty: begin
                d_bundle = head;
                d_valid  = 1'b1;
            end
            byp: begin
                d_bundle = f_bundle;
                d_valid  = 1'b1;
            end
            default: ;
        endcase
    end

    assign q.d_valid = d_valid;
    assign {
        q.d_stat, q.d_pc, q.d_icode, q.d_ifun,
        q.d_ra, q.d_rb, q.d_valc, q.d_valp
    } = d_bundle;
    assign q.count = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed vector table, reset/bypass
// sequences, and random traffic against a queue-based reference model.
module tb_fetch_decode_queue;
    import fetch_decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = FD_PC_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_decode_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    fetch_decode_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    int total = 0;
    int bad   = 0;

    fd_bundle_t mq[$];
    logic       mhalt;

    typedef struct {
        logic        v;
        logic        st;
        logic        bub;
        logic [2:0]  stat;
        logic [63:0] pc;
        logic        rdy;
        logic        dv;
        int          cnt;
        logic [63:0] dpc;
        logic [3:0]  ic;
        logic [2:0]  dst;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [255:0] got,
                         input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    function automatic fd_bundle_t mk(input logic [63:0] pc, input stat_e s);
        fd_bundle_t b;
        b.stat  = s;
        b.pc    = pc;
        b.icode = 4'h6;
        b.ifun  = 4'h0;
        b.ra    = 4'h1;
        b.rb    = 4'h2;
        b.valc  = pc + 64'd100;
        b.valp  = pc + 64'd10;
        return b;
    endfunction

    function automatic fd_bundle_t dut_head();
        return fd_bundle_t'({bus.d_stat, bus.d_pc, bus.d_icode, bus.d_ifun,
                             bus.d_ra, bus.d_rb, bus.d_valc, bus.d_valp});
    endfunction

    task automatic drive(input logic v, input logic st, input logic bub,
                         input fd_bundle_t b);
        bus.f_valid  = v;
        bus.d_stall  = st;
        bus.d_bubble = bub;
        bus.f_stat   = b.stat;
        bus.f_pc     = b.pc;
        bus.f_icode  = b.icode;
        bus.f_ifun   = b.ifun;
        bus.f_ra     = b.ra;
        bus.f_rb     = b.rb;
        bus.f_valc   = b.valc;
        bus.f_valp   = b.valp;
    endtask

    task automatic add(input logic v, input logic st, input logic bub,
                       input logic [2:0] stat, input logic [63:0] pc,
                       input logic rdy, input logic dv, input int cnt,
                       input logic [63:0] dpc, input logic [3:0] ic,
                       input logic [2:0] dst);
        vec_t r;
        r = '{v, st, bub, stat, pc, rdy, dv, cnt, dpc, ic, dst};
        tbl.push_back(r);
    endtask

    // Checks current outputs against the model, then advances the model
    // as of the coming clock edge.
    task automatic model_step(input logic v, input logic st, input logic bub,
                              input fd_bundle_t b);
        int         n;
        logic       mpop;
        logic       rdy;
        logic       byp;
        logic       ev;
        fd_bundle_t eb;
        n    = mq.size();
        mpop = (n > 0) && !st && !bub;
        rdy  = !mhalt && !bub && ((n < DEPTH) || mpop);
        byp  = 1'b0;
`ifdef FDQ_BYPASS_EN
        byp  = (n == 0) && v && rdy && !st;
`endif
        ev = (n > 0) || byp;
        eb = (n > 0) ? mq[0] : (byp ? b : FD_BUBBLE);
        check("rnd_ready", 256'(bus.f_ready), 256'(rdy));
        check("rnd_valid", 256'(bus.d_valid), 256'(ev));
        check("rnd_count", 256'(bus.count), 256'(n));
        check("rnd_head", 256'(dut_head()), 256'(eb));
        if (bub) begin
            mq.delete();
            mhalt = 1'b0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (v && rdy) begin
                if (!byp) mq.push_back(b);
                if (b.stat != SAOK) mhalt = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, mk(64'h0, SAOK));
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mhalt = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, mk(64'h0, SAOK));
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 256'(bus.count), 256'(0));
        check("rst_valid", 256'(bus.d_valid), 256'(0));
        check("rst_head", 256'(dut_head()), 256'(FD_BUBBLE));
        rst = 1'b0;

        // Reset asserted while three entries are held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, mk(64'h200 + 64'(i * 8), SAOK));
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, mk(64'h0, SAOK));
        #1;
        check("mid_count3", 256'(bus.count), 256'(3));
        rst = 1'b1;
        #1;
        check("mid_rst_count", 256'(bus.count), 256'(0));
        check("mid_rst_valid", 256'(bus.d_valid), 256'(0));
        check("mid_rst_icode", 256'(bus.d_icode), 256'(INOP));
        check("mid_rst_ra", 256'(bus.d_ra), 256'(4'hF));
        @(negedge clk);
        rst = 1'b0;

`ifndef FDQ_BYPASS_EN
        add(1,0,0,1,64'h0,   1,0,0,64'h0,  1,1);
        add(1,0,0,1,64'hA,   1,1,1,64'h0,  6,1);
        add(1,0,0,1,64'h14,  1,1,1,64'hA,  6,1);
        add(0,0,0,1,64'h0,   1,1,1,64'h14, 6,1);
        add(0,0,0,1,64'h0,   1,0,0,64'h0,  1,1);
        add(1,1,0,1,64'h100, 1,0,0,64'h0,  1,1);
        add(1,1,0,1,64'h108, 1,1,1,64'h100,6,1);
        add(1,1,0,1,64'h110, 1,1,2,64'h100,6,1);
        add(1,1,0,1,64'h118, 1,1,3,64'h100,6,1);
        add(1,1,0,1,64'h120, 0,1,4,64'h100,6,1);
        add(1,0,0,1,64'h120, 1,1,4,64'h100,6,1);
        add(1,0,0,1,64'h128, 1,1,4,64'h108,6,1);
        add(1,0,0,1,64'h130, 1,1,4,64'h110,6,1);
        add(0,0,0,1,64'h0,   1,1,4,64'h118,6,1);
        add(0,0,0,1,64'h0,   1,1,3,64'h120,6,1);
        add(0,0,0,1,64'h0,   1,1,2,64'h128,6,1);
        add(0,0,0,1,64'h0,   1,1,1,64'h130,6,1);
        add(0,0,0,1,64'h0,   1,0,0,64'h0,  1,1);
        add(1,0,0,1,64'h18,  1,0,0,64'h0,  1,1);
        add(1,0,0,2,64'h20,  1,1,1,64'h18, 6,1);
        add(1,1,0,1,64'h28,  0,1,1,64'h20, 6,2);
        add(1,0,0,1,64'h28,  0,1,1,64'h20, 6,2);
        add(1,0,0,1,64'h28,  0,0,0,64'h0,  1,1);
        add(1,0,1,1,64'h28,  0,0,0,64'h0,  1,1);
        add(0,0,0,1,64'h0,   1,0,0,64'h0,  1,1);
        add(1,1,0,1,64'h30,  1,0,0,64'h0,  1,1);
        add(1,1,0,1,64'h38,  1,1,1,64'h30, 6,1);
        add(1,1,1,1,64'h40,  0,1,2,64'h30, 6,1);
        add(0,0,0,1,64'h0,   1,0,0,64'h0,  1,1);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].st, tbl[i].bub,
                  mk(tbl[i].pc, stat_e'(tbl[i].stat)));
            #1;
            check($sformatf("v%0d_ready", i), 256'(bus.f_ready), 256'(tbl[i].rdy));
            check($sformatf("v%0d_valid", i), 256'(bus.d_valid), 256'(tbl[i].dv));
            check($sformatf("v%0d_count", i), 256'(bus.count), 256'(tbl[i].cnt));
            check($sformatf("v%0d_pc", i), 256'(bus.d_pc), 256'(tbl[i].dpc));
            check($sformatf("v%0d_icode", i), 256'(bus.d_icode), 256'(tbl[i].ic));
            check($sformatf("v%0d_stat", i), 256'(bus.d_stat), 256'(tbl[i].dst));
        end
`else
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, mk(64'h50, SAOK));
        #1;
        check("byp_pc", 256'(bus.d_pc), 256'(64'h50));
        check("byp_valid", 256'(bus.d_valid), 256'(1));
        check("byp_count", 256'(bus.count), 256'(0));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, mk(64'h0, SAOK));
        #1;
        check("byp_after_count", 256'(bus.count), 256'(0));
        check("byp_after_valid", 256'(bus.d_valid), 256'(0));
`endif

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            fd_bundle_t b;
            logic       v;
            logic       st;
            logic       bub;
            b.stat  = ($urandom_range(0, 19) == 0) ?
                      stat_e'($urandom_range(2, 4)) : SAOK;
            b.pc    = {$urandom, $urandom};
            b.icode = 4'($urandom);
            b.ifun  = 4'($urandom);
            b.ra    = 4'($urandom);
            b.rb    = 4'($urandom);
            b.valc  = {$urandom, $urandom};
            b.valp  = {$urandom, $urandom};
            v   = ($urandom_range(0, 9) < 7);
            st  = ($urandom_range(0, 9) < 4);
            bub = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            drive(v, st, bub, b);
            #1;
            model_step(v, st, bub, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
